// File: rtl/spi_bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_bus_arbiter_if
// Purpose  : Bundles both SPI master request/pin groups, the flash pins and
//            the arbiter status outputs into one interface.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface spi_bus_arbiter_if;
  // 6809-side flash controller
  logic       i_ctrl_req;
  logic       i_ctrl_spi_clk;
  logic       i_ctrl_spi_mosi;
  logic       i_ctrl_spi_cs;
  // FT2232 host programming path
  logic       i_host_cs_n;
  logic       i_host_spi_clk;
  logic       i_host_spi_mosi;
  logic       i_host_spi_cs;
  // Arbiter results and flash pins
  logic       o_ctrl_grant;
  logic       o_host_grant;
  logic       o_SPI_CLK;
  logic       o_SPI_MOSI;
  logic       o_SPI_CS;
  logic       o_cpu_stall;
  logic       o_timeout;
  logic       o_host_conflict;
  logic [1:0] o_owner;

  // Arbiter side
  modport slave (
    input  i_ctrl_req, i_ctrl_spi_clk, i_ctrl_spi_mosi, i_ctrl_spi_cs,
    input  i_host_cs_n, i_host_spi_clk, i_host_spi_mosi, i_host_spi_cs,
    output o_ctrl_grant, o_host_grant, o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
    output o_cpu_stall, o_timeout, o_host_conflict, o_owner
  );

  // Side that drives the requests and observes the results
  modport master (
    output i_ctrl_req, i_ctrl_spi_clk, i_ctrl_spi_mosi, i_ctrl_spi_cs,
    output i_host_cs_n, i_host_spi_clk, i_host_spi_mosi, i_host_spi_cs,
    input  o_ctrl_grant, o_host_grant, o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
    input  o_cpu_stall, o_timeout, o_host_conflict, o_owner
  );
endinterface
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : spi_bus_arbiter
// Purpose  : Owns the single SPI flash bus on behalf of either the 6809 flash
//            controller or the FT2232 host path, with a guard interval
//            (CS high) between owners, a CPU stall/timeout for the controller
//            and a sticky host-conflict flag.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int SYNC_STAGES   = 2,
  parameter int GUARD_CYCLES  = 4,
  parameter bit HOST_PRIORITY = 1'b1,
  parameter int MAX_WAIT      = 255,
  parameter bit CLK_IDLE      = 1'b0
) (
  input  wire logic          clk,
  input  wire logic          reset,
  spi_bus_arbiter_if.slave   io_bus
);

  // Guard counter only needs to hold GUARD_CYCLES-1 down to 0
  localparam int              GW           = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0]   c_guard_load = GW'(GUARD_CYCLES - 1);
  localparam logic [7:0]      c_wait_max   = 8'(MAX_WAIT);

  // Encoding doubles as the o_owner status code
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CTRL  = 2'b01,
    ST_HOST  = 2'b10,
    ST_GUARD = 2'b11
  } state_t;

  state_t                 r_state;
  logic                   r_ctrl_grant;
  logic                   r_host_grant;
  logic                   r_host_conflict;
  logic [GW-1:0]          r_guard_cnt;
  logic [7:0]             r_wait_cnt;
  logic [SYNC_STAGES-1:0] r_host_sync;

  logic w_host_req;
  logic w_stall;
  logic w_spi_clk;
  logic w_spi_mosi;
  logic w_spi_cs;

  // Synchronize the asynchronous host chip-select; idles high (no request)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_host_sync <= '1;
    end else begin
      r_host_sync <= {r_host_sync[SYNC_STAGES-2:0], io_bus.i_host_cs_n};
    end
  end

  assign w_host_req = ~r_host_sync[SYNC_STAGES-1];

  // Owner state machine with registered grants, guard timer and conflict flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_ctrl_grant    <= 1'b0;
      r_host_grant    <= 1'b0;
      r_guard_cnt     <= '0;
      r_host_conflict <= 1'b0;
    end else begin
      // A host request seen while the controller holds the bus is remembered
      if (r_state == ST_CTRL && w_host_req) begin
        r_host_conflict <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_host_req && (!io_bus.i_ctrl_req || HOST_PRIORITY)) begin
            r_state      <= ST_HOST;
            r_host_grant <= 1'b1;
          end else if (io_bus.i_ctrl_req) begin
            r_state      <= ST_CTRL;
            r_ctrl_grant <= 1'b1;
          end
        end
        ST_CTRL: begin
          // Only release once the controller has also deasserted its CS
          if (!io_bus.i_ctrl_req && io_bus.i_ctrl_spi_cs) begin
            r_state      <= ST_GUARD;
            r_ctrl_grant <= 1'b0;
            r_guard_cnt  <= c_guard_load;
          end
        end
        ST_HOST: begin
          if (!w_host_req) begin
            r_state      <= ST_GUARD;
            r_host_grant <= 1'b0;
            r_guard_cnt  <= c_guard_load;
          end
        end
        default: begin
          if (r_guard_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_guard_cnt <= r_guard_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Route the owner's pins to the flash; everyone else sees an idle bus
  always_comb begin
    w_spi_clk  = CLK_IDLE;
    w_spi_mosi = 1'b0;
    w_spi_cs   = 1'b1;
    case (r_state)
      ST_CTRL: begin
        w_spi_clk  = io_bus.i_ctrl_spi_clk;
        w_spi_mosi = io_bus.i_ctrl_spi_mosi;
        w_spi_cs   = io_bus.i_ctrl_spi_cs;
      end
      ST_HOST: begin
        w_spi_clk  = io_bus.i_host_spi_clk;
        w_spi_mosi = io_bus.i_host_spi_mosi;
        w_spi_cs   = io_bus.i_host_spi_cs;
      end
      default: ;
    endcase
  end

  // Stall is held off during reset so MRDY is released while the block restarts
  assign w_stall = io_bus.i_ctrl_req & ~r_ctrl_grant & ~reset;

  // Count consecutive stall cycles, saturating so the timeout fires only once
  always_ff @(posedge clk) begin
    if (reset || !w_stall) begin
      r_wait_cnt <= 8'd0;
    end else if (r_wait_cnt != c_wait_max) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign io_bus.o_ctrl_grant    = r_ctrl_grant;
  assign io_bus.o_host_grant    = r_host_grant;
  assign io_bus.o_SPI_CLK       = w_spi_clk;
  assign io_bus.o_SPI_MOSI      = w_spi_mosi;
  assign io_bus.o_SPI_CS        = w_spi_cs;
  assign io_bus.o_cpu_stall     = w_stall;
  // Fires during the stall cycle in which the counter steps onto MAX_WAIT
  assign io_bus.o_timeout       = w_stall & (r_wait_cnt == (c_wait_max - 8'd1));
  assign io_bus.o_host_conflict = r_host_conflict;
  assign io_bus.o_owner         = r_state;

endmodule
`default_nettype wire

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
Arbitrates the single external SPI flash bus between two masters. One is the 6809-side flash read/write controller; the other is the FT2232 host programming path. It replaces the bare CS-select mux with a registered owner state machine and a guard interval between owners. It also provides a CPU stall output for MRDY stretching and conflict/timeout status. It sits between both SPI masters and the o_SPI_CLK/o_SPI_MOSI/o_SPI_CS pins, clocked by the internal oscillator.

Parameters:
SYNC_STAGES, 2, flops in the synchronizer on the asynchronous host chip-select (min 2)
GUARD_CYCLES, 4, clk cycles with flash CS forced high between any release and the next grant (min 1)
HOST_PRIORITY, 1, 1 = host wins simultaneous requests in IDLE; 0 = controller wins
MAX_WAIT, 255, controller wait cycles before o_timeout pulses (8-bit counter, 1..255)
CLK_IDLE, 0, SPI clock level driven when no master owns the bus

Ports:
clk  input  1  internal oscillator clock
reset  input  1  synchronous, active-high reset
i_ctrl_req  input  1  controller requests the bus (level, held through transfer)
i_ctrl_spi_clk  input  1  controller SPI clock
i_ctrl_spi_mosi  input  1  controller MOSI
i_ctrl_spi_cs  input  1  controller flash CS, active low
i_host_cs_n  input  1  FT2232 chip select, active low, asynchronous to clk; low = host request
i_host_spi_clk  input  1  host-path SPI clock
i_host_spi_mosi  input  1  host-path MOSI
i_host_spi_cs  input  1  host-path flash CS, active low
o_ctrl_grant  output  1  controller owns the bus
o_host_grant  output  1  host owns the bus
o_SPI_CLK  output  1  flash SPI clock
o_SPI_MOSI  output  1  flash MOSI
o_SPI_CS  output  1  flash CS, active low
o_cpu_stall  output  1  high = controller waiting; drives MRDY low upstream
o_timeout  output  1  one-cycle pulse when controller wait reaches MAX_WAIT
o_host_conflict  output  1  sticky; host requested while controller owned the bus
o_owner  output  2  00 idle, 01 ctrl, 10 host, 11 guard

Behaviour:
- Single clock domain (clk). All state updates on the rising edge. reset is synchronous and active-high.
- Reset values:
  - state=IDLE, grants=0, o_owner=00
  - o_SPI_CS=1, o_SPI_CLK=CLK_IDLE, o_SPI_MOSI=0
  - o_cpu_stall=0, o_timeout=0, o_host_conflict=0
  - wait counter=0, guard counter=0, synchronizer flops=1
- Host request: host_req = inverted output of a SYNC_STAGES-deep chain on i_host_cs_n. Latency is SYNC_STAGES cycles.
- State IDLE:
  - host_req only -> HOST_OWN.
  - i_ctrl_req only -> CTRL_OWN.
  - Both -> HOST_OWN if HOST_PRIORITY=1, else CTRL_OWN.
  - Grant is registered: it is visible one cycle after the request is sampled in IDLE.
- State CTRL_OWN:
  - o_ctrl_grant=1; pins follow the ctrl inputs combinationally.
  - Exit to GUARD when i_ctrl_req=0 and i_ctrl_spi_cs=1 in the same cycle.
  - A host request never preempts the controller.
- State HOST_OWN:
  - o_host_grant=1; pins follow the host inputs.
  - Exit to GUARD when host_req=0.
  - The controller never preempts the host.
- State GUARD:
  - o_SPI_CS=1, o_SPI_CLK=CLK_IDLE, o_SPI_MOSI=0; no grants.
  - Guard counter loads GUARD_CYCLES-1 on entry. Return to IDLE when it reaches 0, so exactly GUARD_CYCLES cycles in GUARD.
- Non-owner pin inputs are ignored. CS can only go low while a grant is high.
- o_cpu_stall = i_ctrl_req & ~o_ctrl_grant (combinational from the registered grant). It is 0 when i_ctrl_req=0.
- Wait counter:
  - Increments each cycle o_cpu_stall=1 and saturates at MAX_WAIT.
  - o_timeout pulses for exactly one cycle on the transition to MAX_WAIT.
  - Counter clears when the grant is given or i_ctrl_req drops.
- o_host_conflict is set when host_req=1 while in CTRL_OWN. It clears only on reset.
- Simultaneous release and new request in the same cycle: the release wins, and the FSM still passes through GUARD.
- Reset mid-transfer: the next cycle forces IDLE and CS high regardless of the master inputs.

Test Plan:
1. Reset with both masters driving CS low -> o_SPI_CS=1, o_owner=00, grants=0 the cycle after reset, held while reset=1.
2. i_ctrl_req=1 alone (SYNC_STAGES=2, GUARD_CYCLES=4) -> o_ctrl_grant=1 one cycle later; o_SPI_CLK/o_SPI_MOSI/o_SPI_CS mirror the ctrl inputs. Drop request with ctrl CS=1 -> o_owner=11 for exactly 4 cycles, then 00.
3. i_host_cs_n falls while ctrl owns -> o_host_conflict=1, host not granted. After ctrl release -> 4 guard cycles, then o_host_grant=1; o_SPI_CS follows i_host_spi_cs.
4. Both request in the same IDLE cycle: HOST_PRIORITY=1 -> host granted; HOST_PRIORITY=0 -> ctrl granted.
5. Host holds the bus, ctrl requests for 300 cycles (MAX_WAIT=255) -> o_cpu_stall=1 throughout; o_timeout=1 exactly once, on the 255th stall cycle; counter clears on grant.
6. Assert reset mid-CTRL_OWN transfer -> next cycle o_SPI_CS=1 and o_ctrl_grant=0. After reset release with request still high -> regrant via IDLE.
